// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered, handshaked ALU-control decode stage between ID and EX.
// Ports: Clk, Rst_n, in_valid/in_ready, opcode, funct, flush, out_valid/out_ready,
//   alu_ctrl, is_mul, is_branch, is_jump, illegal, err_sticky, err_clr.
//   Optional macro ALUCTL_ERR_STICKY_EN enables the sticky illegal flag.
module alu_ctrl_seq #(
  parameter int CTRL_W     = 6,
  parameter int MUL_CYCLES = 3
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              is_mul,
  output logic              is_branch,
  output logic              is_jump,
  output logic              illegal,
  output logic              err_sticky,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);
  localparam bit MUL_HOLD = (MUL_CYCLES > 1);

  typedef enum logic {IDLE, MUL_WAIT} state_t;

  typedef struct packed {
    logic [5:0] code;
    logic       mul;
    logic       br;
    logic       jmp;
    logic       ill;
  } res_t;

  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       ov_q, ov_d;
  res_t       out_q, out_d;
  res_t       hold_q, hold_d;
  res_t       dec;
  logic       accept;
  logic       load;

  always_comb begin
    dec = '{code: 6'h3f, mul: 1'b0, br: 1'b0,
            jmp: 1'b0, ill: 1'b0};
    if (opcode == 6'b000000) begin
      unique case (funct)
        6'b100000, 6'b100010, 6'b100100,
        6'b100101, 6'b100111, 6'b100110,
        6'b000000, 6'b000010, 6'b101010:
          dec.code = funct;
        6'b011000: begin
          dec.code = funct;
          dec.mul  = 1'b1;
        end
        6'b001000: dec.jmp = 1'b1;
        default:   dec.ill = 1'b1;
      endcase
    end else begin
      unique case (opcode)
        6'b100011, 6'b101011, 6'b100000,
        6'b101000, 6'b100001, 6'b101001,
        6'b001000:
          dec.code = 6'b100000;
        6'b001100: dec.code = 6'b100100;
        6'b001101: dec.code = 6'b100101;
        6'b001110: dec.code = 6'b100110;
        6'b001010: dec.code = 6'b101010;
        6'b000001, 6'b000100, 6'b000101,
        6'b000110, 6'b000111: begin
          dec.code = opcode;
          dec.br   = 1'b1;
        end
        6'b000010, 6'b000011: dec.jmp = 1'b1;
        default:              dec.ill = 1'b1;
      endcase
    end
  end

  assign in_ready = Rst_n && (state_q == IDLE)
                 && (!ov_q || out_ready) && !flush;
  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    out_d   = out_q;
    hold_d  = hold_q;
    load    = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      ov_d    = 1'b0;
    end else begin
      if (ov_q && out_ready) ov_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (dec.mul && MUL_HOLD) begin
              state_d = MUL_WAIT;
              cnt_d   = CNT_W'(MUL_CYCLES - 1);
              hold_d  = dec;
            end else begin
              ov_d  = 1'b1;
              out_d = dec;
              load  = 1'b1;
            end
          end
        end
        MUL_WAIT: begin
          // Counter runs down to 0; the following edge publishes,
          // giving MUL_CYCLES edges from acceptance to out_valid.
          if (cnt_q == '0) begin
            state_d = IDLE;
            ov_d    = 1'b1;
            out_d   = hold_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      out_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      out_q   <= out_d;
      hold_q  <= hold_d;
    end
  end

`ifdef ALUCTL_ERR_STICKY_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (load && out_d.ill) err_d = 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_sticky = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_sticky = 1'b0;
`endif

  assign out_valid = ov_q;
  assign alu_ctrl  = CTRL_W'(out_q.code);
  // Stale flags are masked so only a valid result reports them.
  assign is_mul    = ov_q & out_q.mul;
  assign is_branch = ov_q & out_q.br;
  assign is_jump   = ov_q & out_q.jmp;
  assign illegal   = ov_q & out_q.ill;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed self-checking bench for alu_ctrl_seq.
// Default parameters: CTRL_W=6, MUL_CYCLES=3.
module tb_alu_ctrl_seq;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] alu_ctrl;
  logic       is_mul;
  logic       is_branch;
  logic       is_jump;
  logic       illegal;
  logic       err_sticky;
  logic       err_clr;

  int checks = 0;
  int failures = 0;

`ifdef ALUCTL_ERR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  alu_ctrl_seq #(.CTRL_W(6), .MUL_CYCLES(3)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl),
    .is_mul(is_mul), .is_branch(is_branch),
    .is_jump(is_jump), .illegal(illegal),
    .err_sticky(err_sticky), .err_clr(err_clr)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; in_valid = 1'b0; opcode = '0;
    funct = '0; flush = 1'b0; out_ready = 1'b0;
    err_clr = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || alu_ctrl !== 6'd0) begin
      failures++;
      $display("FAIL reset_out ov=%b ctrl=%b want 0/000000",
               out_valid, alu_ctrl);
    end
    checks++;
    if (in_ready !== 1'b0 || err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdy rdy=%b err=%b want 0/0",
               in_ready, err_sticky);
    end
    Rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_ori();
    out_ready = 1'b1; in_valid = 1'b1;
    opcode = 6'b000000; funct = 6'b100000;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL add_rdy got=%b want=1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || alu_ctrl !== 6'b100000) begin
      failures++;
      $display("FAIL add ov=%b ctrl=%b want 1/100000",
               out_valid, alu_ctrl);
    end
    opcode = 6'b001101;
    tick();
    checks++;
    if (out_valid !== 1'b1 || alu_ctrl !== 6'b100101) begin
      failures++;
      $display("FAIL ori_b2b ov=%b ctrl=%b want 1/100101",
               out_valid, alu_ctrl);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain got=%b want=0", out_valid);
    end
  endtask

  task automatic test_mul();
    out_ready = 1'b1; in_valid = 1'b1;
    opcode = 6'b000000; funct = 6'b011000;
    tick();
    funct = 6'b100000;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL mul_wait%0d rdy=%b ov=%b want 0/0",
                 i, in_ready, out_valid);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mul_early ov=%b want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || alu_ctrl !== 6'b011000
        || is_mul !== 1'b1) begin
      failures++;
      $display("FAIL mul_out ov=%b ctrl=%b mul=%b want 1/011000/1",
               out_valid, alu_ctrl, is_mul);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || alu_ctrl !== 6'b100000
        || is_mul !== 1'b0) begin
      failures++;
      $display("FAIL mul_next ov=%b ctrl=%b mul=%b want 1/100000/0",
               out_valid, alu_ctrl, is_mul);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1;
    opcode = 6'b000100; funct = 6'b000000;
    tick();
    opcode = 6'b001110;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || alu_ctrl !== 6'b000100
          || is_branch !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d ov=%b ctrl=%b br=%b rdy=%b want 1/000100/1/0",
                 i, out_valid, alu_ctrl, is_branch, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release rdy=%b want 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || alu_ctrl !== 6'b100110
        || is_branch !== 1'b0) begin
      failures++;
      $display("FAIL bp_next ov=%b ctrl=%b br=%b want 1/100110/0",
               out_valid, alu_ctrl, is_branch);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b1; in_valid = 1'b1;
    opcode = 6'b000000; funct = 6'b011000;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_mul ov=%b rdy=%b want 0/1",
               out_valid, in_ready);
    end
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_ghost ov=%b want 0", out_valid);
    end
    in_valid = 1'b1; funct = 6'b100010;
    tick();
    flush = 1'b1;
    funct = 6'b100100;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_wins ov=%b want 0", out_valid);
    end
    tick();
  endtask

  task automatic test_jumps();
    logic [5:0] op_t [4] = '{6'b000000, 6'b000010,
                             6'b000011, 6'b000000};
    logic [5:0] fn_t [4] = '{6'b001000, 6'b000000,
                             6'b000000, 6'b000111};
    logic       jp_t [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       il_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1; err_clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; opcode = op_t[i]; funct = fn_t[i];
      tick();
      checks++;
      if (out_valid !== 1'b1 || alu_ctrl !== 6'b111111
          || is_jump !== jp_t[i] || illegal !== il_t[i]) begin
        failures++;
        $display("FAIL jump%0d ov=%b ctrl=%b j=%b ill=%b want 1/111111/%b/%b",
                 i, out_valid, alu_ctrl, is_jump, illegal,
                 jp_t[i], il_t[i]);
      end
    end
    // Last vector loaded an illegal op with err_clr high: set wins.
    checks++;
    if (err_sticky !== STICKY) begin
      failures++;
      $display("FAIL set_wins err=%b want %b", err_sticky, STICKY);
    end
    err_clr = 1'b1; in_valid = 1'b0;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_illegal();
    logic [5:0] op_t [5] = '{6'b001000, 6'b100011,
                             6'b001100, 6'b001010, 6'b000101};
    logic [5:0] cd_t [5] = '{6'b100000, 6'b100000,
                             6'b100100, 6'b101010, 6'b000101};
    out_ready = 1'b1; in_valid = 1'b1;
    opcode = 6'b111111; funct = 6'b000000;
    tick();
    checks++;
    if (illegal !== 1'b1 || alu_ctrl !== 6'b111111
        || err_sticky !== STICKY) begin
      failures++;
      $display("FAIL illegal ill=%b ctrl=%b err=%b want 1/111111/%b",
               illegal, alu_ctrl, err_sticky, STICKY);
    end
    for (int i = 0; i < 5; i++) begin
      opcode = op_t[i];
      tick();
      checks++;
      if (illegal !== 1'b0 || alu_ctrl !== cd_t[i]
          || err_sticky !== STICKY) begin
        failures++;
        $display("FAIL legal%0d ill=%b ctrl=%b err=%b want 0/%b/%b",
                 i, illegal, alu_ctrl, err_sticky, cd_t[i], STICKY);
      end
    end
    in_valid = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL err_clr err=%b want 0", err_sticky);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    opcode = 6'b111111;
    tick();
    in_valid = 1'b0;
    #2;
    Rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || alu_ctrl !== 6'd0
        || err_sticky !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL async_rst ov=%b ctrl=%b err=%b rdy=%b want 0/0/0/0",
               out_valid, alu_ctrl, err_sticky, in_ready);
    end
    #3;
    Rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_add_ori();
    test_mul();
    test_backpressure();
    test_flush();
    test_jumps();
    test_illegal();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
